// File: rtl/uart_debug_controller_if.sv
// UART FIFO handshake bundle between uart_debug_controller and the UART block.
// Signal prefixes are relative to the controller: i_* flow into it, o_* flow out.
//   i_uart_rx_data   RX FIFO head byte (valid while i_uart_rx_empty = 0)
//   i_uart_rx_empty  RX FIFO empty
//   i_uart_tx_full   TX FIFO full
//   o_uart_rd        pop RX FIFO (1-cycle pulse)
//   o_uart_wr        push o_uart_wdata into TX FIFO (1-cycle pulse)
//   o_uart_wdata     TX byte
//   o_uart_tx_start  start transmission of queued bytes (1-cycle pulse)
interface uart_debug_controller_if #(
  parameter int unsigned NB_UART_DATA = 8
);
  logic [NB_UART_DATA-1:0] i_uart_rx_data;
  logic                    i_uart_rx_empty;
  logic                    i_uart_tx_full;
  logic                    o_uart_rd;
  logic                    o_uart_wr;
  logic [NB_UART_DATA-1:0] o_uart_wdata;
  logic                    o_uart_tx_start;

  // Controller side.
  modport master (
    input  i_uart_rx_data, i_uart_rx_empty, i_uart_tx_full,
    output o_uart_rd, o_uart_wr, o_uart_wdata, o_uart_tx_start
  );

  // UART side.
  modport slave (
    output i_uart_rx_data, i_uart_rx_empty, i_uart_tx_full,
    input  o_uart_rd, o_uart_wr, o_uart_wdata, o_uart_tx_start
  );
endinterface

// File: rtl/uart_debug_controller.sv
// Debug command sequencer between the UART and the CPU subsystem.
// Commands popped from the RX FIFO: 'L' load program words, 'R' run to halt,
// 'S' single step, 'D' dump register file; anything else is answered with NAK.
// Ports:
//   clk, i_rst         clock, asynchronous active-low reset
//   uart_if            UART RX/TX FIFO handshake (master modport)
//   o_imem_we/addr/wdata  instruction memory write port
//   o_cpu_en, i_cpu_halt  CPU clock enable and halt status
//   o_dbg_addr, i_dbg_rdata  register-file debug read port (1-cycle latency)
module uart_debug_controller #(
  parameter int unsigned NB_DATA         = 32,
  parameter int unsigned NB_UART_DATA    = 8,
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter int unsigned NB_REG_ADDR     = 5
) (
  input  logic                       clk,
  input  logic                       i_rst,
  uart_debug_controller_if.master    uart_if,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [NB_DATA-1:0]         o_imem_wdata,
  output logic                       o_cpu_en,
  input  logic                       i_cpu_halt,
  output logic [NB_REG_ADDR-1:0]     o_dbg_addr,
  input  logic [NB_DATA-1:0]         i_dbg_rdata
);

  localparam int unsigned NB_BYTES = NB_DATA / NB_UART_DATA;
  localparam int unsigned NB_BIDX  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int unsigned NB_CNT   = NB_UART_DATA + 1;  // holds 256 for a zero count byte

  localparam logic [NB_BIDX-1:0]      LastByte = NB_BIDX'(NB_BYTES - 1);
  localparam logic [NB_UART_DATA-1:0] CmdLoad  = NB_UART_DATA'(8'h4C);
  localparam logic [NB_UART_DATA-1:0] CmdRun   = NB_UART_DATA'(8'h52);
  localparam logic [NB_UART_DATA-1:0] CmdStep  = NB_UART_DATA'(8'h53);
  localparam logic [NB_UART_DATA-1:0] CmdDump  = NB_UART_DATA'(8'h44);
  localparam logic [NB_UART_DATA-1:0] RspAck   = NB_UART_DATA'(8'h06);
  localparam logic [NB_UART_DATA-1:0] RspNak   = NB_UART_DATA'(8'h15);
  localparam logic [NB_UART_DATA-1:0] RspHalt  = NB_UART_DATA'(8'h48);

  typedef enum logic [3:0] {
    StIdle, StLdCnt, StLdByte, StLdWr, StRun, StStep, StDumpAddr, StDumpTx, StReply, StKick
  } state_e;

  state_e                     r_state,     w_state_d;
  logic [NB_CNT-1:0]          r_cnt,       w_cnt_d;
  logic [NB_BIDX-1:0]         r_bidx,      w_bidx_d;
  logic [NB_DATA-1:0]         r_word,      w_word_d;
  logic [IMEM_ADDR_WIDTH-1:0] r_imem_addr, w_imem_addr_d;
  logic [NB_REG_ADDR-1:0]     r_dbg_addr,  w_dbg_addr_d;
  logic [NB_DATA-1:0]         r_data,      w_data_d;
  logic                       r_have,      w_have_d;
  logic [NB_UART_DATA-1:0]    r_reply,     w_reply_d;
  logic                       r_cpu_en,    w_cpu_en_d;
  logic                       w_rd;
  logic                       w_wr;
  logic [NB_UART_DATA-1:0]    w_wdata;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bidx      <= '0;
      r_word      <= '0;
      r_imem_addr <= '0;
      r_dbg_addr  <= '0;
      r_data      <= '0;
      r_have      <= 1'b0;
      r_reply     <= '0;
      r_cpu_en    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_bidx      <= w_bidx_d;
      r_word      <= w_word_d;
      r_imem_addr <= w_imem_addr_d;
      r_dbg_addr  <= w_dbg_addr_d;
      r_data      <= w_data_d;
      r_have      <= w_have_d;
      r_reply     <= w_reply_d;
      r_cpu_en    <= w_cpu_en_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_bidx_d      = r_bidx;
    w_word_d      = r_word;
    w_imem_addr_d = r_imem_addr;
    w_dbg_addr_d  = r_dbg_addr;
    w_data_d      = r_data;
    w_have_d      = r_have;
    w_reply_d     = r_reply;
    w_cpu_en_d    = r_cpu_en;
    w_rd          = 1'b0;
    w_wr          = 1'b0;
    w_wdata       = '0;

    unique case (r_state)
      StIdle: begin
        if (!uart_if.i_uart_rx_empty) begin
          w_rd = 1'b1;
          case (uart_if.i_uart_rx_data)
            CmdLoad: w_state_d = StLdCnt;
            CmdRun:  w_state_d = StRun;
            CmdStep: begin
              w_state_d  = StStep;
              w_cpu_en_d = 1'b1;  // registered, so it is high exactly while in StStep
            end
            CmdDump: begin
              w_state_d    = StDumpAddr;
              w_dbg_addr_d = '0;
            end
            default: begin
              w_reply_d = RspNak;
              w_state_d = StReply;
            end
          endcase
        end
      end
      StLdCnt: begin
        if (!uart_if.i_uart_rx_empty) begin
          w_rd          = 1'b1;
          w_cnt_d       = (uart_if.i_uart_rx_data == '0) ? {1'b1, {NB_UART_DATA{1'b0}}}
                                                         : {1'b0, uart_if.i_uart_rx_data};
          w_imem_addr_d = '0;
          w_bidx_d      = '0;
          w_state_d     = StLdByte;
        end
      end
      StLdByte: begin
        if (!uart_if.i_uart_rx_empty) begin
          w_rd = 1'b1;
          w_word_d[32'(r_bidx) * NB_UART_DATA +: NB_UART_DATA] = uart_if.i_uart_rx_data;
          if (r_bidx == LastByte) begin
            w_bidx_d  = '0;
            w_state_d = StLdWr;
          end else begin
            w_bidx_d = r_bidx + NB_BIDX'(1);
          end
        end
      end
      StLdWr: begin
        w_imem_addr_d = r_imem_addr + IMEM_ADDR_WIDTH'(1);
        w_cnt_d       = r_cnt - NB_CNT'(1);
        if (r_cnt == NB_CNT'(1)) begin
          w_reply_d = RspAck;
          w_state_d = StReply;
        end else begin
          w_state_d = StLdByte;
        end
      end
      StRun: begin
        // Enable is raised unconditionally once, so halt-on-entry still gives one cycle.
        if (!r_cpu_en) begin
          w_cpu_en_d = 1'b1;
        end else if (i_cpu_halt) begin
          w_cpu_en_d = 1'b0;
          w_reply_d  = RspHalt;
          w_state_d  = StReply;
        end
      end
      StStep: begin
        w_cpu_en_d = 1'b0;
        w_reply_d  = RspAck;
        w_state_d  = StReply;
      end
      StDumpAddr: begin
        // o_dbg_addr is valid this cycle; read data arrives during the next one.
        w_have_d  = 1'b0;
        w_state_d = StDumpTx;
      end
      StDumpTx: begin
        if (!r_have) begin
          w_data_d = i_dbg_rdata;
          w_have_d = 1'b1;
        end else begin
          w_wdata = r_data[32'(r_bidx) * NB_UART_DATA +: NB_UART_DATA];
          if (!uart_if.i_uart_tx_full) begin
            w_wr = 1'b1;
            if (r_bidx == LastByte) begin
              w_bidx_d = '0;
              w_have_d = 1'b0;
              if (r_dbg_addr == '1) begin
                w_state_d = StKick;
              end else begin
                w_dbg_addr_d = r_dbg_addr + NB_REG_ADDR'(1);
                w_state_d    = StDumpAddr;
              end
            end else begin
              w_bidx_d = r_bidx + NB_BIDX'(1);
            end
          end
        end
      end
      StReply: begin
        w_wdata = r_reply;
        if (!uart_if.i_uart_tx_full) begin
          w_wr      = 1'b1;
          w_state_d = StKick;
        end
      end
      StKick:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // rd is the only output decoded from an input in StIdle, so it is gated by reset.
  assign uart_if.o_uart_rd       = w_rd & i_rst;
  assign uart_if.o_uart_wr       = w_wr;
  assign uart_if.o_uart_wdata    = w_wdata;
  assign uart_if.o_uart_tx_start = (r_state == StKick);
  assign o_imem_we               = (r_state == StLdWr);
  assign o_imem_addr             = r_imem_addr;
  assign o_imem_wdata            = (r_state == StLdWr) ? r_word : '0;
  assign o_cpu_en                = r_cpu_en;
  assign o_dbg_addr              = r_dbg_addr;

endmodule

// File: tb/tb_uart_debug_controller.sv
module tb_uart_debug_controller;

  localparam int unsigned NbData    = 32;
  localparam int unsigned NbUart    = 8;
  localparam int unsigned ImemAw    = 8;
  localparam int unsigned NbRegAddr = 5;
  localparam int unsigned NRegs     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_debug_controller_if #(.NB_UART_DATA(NbUart)) u_if ();

  logic                 imem_we;
  logic [ImemAw-1:0]    imem_addr;
  logic [NbData-1:0]    imem_wdata;
  logic                 cpu_en;
  logic                 cpu_halt;
  logic [NbRegAddr-1:0] dbg_addr;
  logic [NbData-1:0]    dbg_rdata;

  uart_debug_controller #(
    .NB_DATA        (NbData),
    .NB_UART_DATA   (NbUart),
    .IMEM_ADDR_WIDTH(ImemAw),
    .NB_REG_ADDR    (NbRegAddr)
  ) u_dut (
    .clk         (clk),
    .i_rst       (rst_n),
    .uart_if     (u_if),
    .o_imem_we   (imem_we),
    .o_imem_addr (imem_addr),
    .o_imem_wdata(imem_wdata),
    .o_cpu_en    (cpu_en),
    .i_cpu_halt  (cpu_halt),
    .o_dbg_addr  (dbg_addr),
    .i_dbg_rdata (dbg_rdata)
  );

  // RX FIFO model: bytes written by the stimulus, popped on o_uart_rd.
  logic [7:0] rx_mem [0:4095];
  int rx_wr = 0;
  int rx_rd = 0;
  assign u_if.i_uart_rx_empty = (rx_rd == rx_wr);
  assign u_if.i_uart_rx_data  = rx_mem[rx_rd[11:0]];
  always @(posedge clk) if (u_if.o_uart_rd && !u_if.i_uart_rx_empty) rx_rd <= rx_rd + 1;

  // Register file model with one cycle of read latency.
  logic [31:0] reg_file [0:NRegs-1];
  always @(posedge clk) dbg_rdata <= reg_file[dbg_addr];

  // Observation logs, sampled mid-cycle.
  logic [7:0]  tx_q[$];
  int unsigned we_addr_q[$];
  logic [31:0] we_data_q[$];
  logic [31:0] ld_words[$];
  int n_start = 0;
  int n_en    = 0;
  int n_viol  = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(negedge clk) begin
    if (u_if.o_uart_wr) tx_q.push_back(u_if.o_uart_wdata);
    if (u_if.o_uart_tx_start) n_start++;
    if (imem_we) begin
      we_addr_q.push_back(imem_addr);
      we_data_q.push_back(imem_wdata);
    end
    if (cpu_en) n_en++;
    if (u_if.o_uart_wr && (u_if.o_uart_tx_start || u_if.i_uart_tx_full)) n_viol++;
    if (u_if.o_uart_rd && u_if.i_uart_rx_empty) n_viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wr[11:0]] = b;
    rx_wr++;
  endtask

  task automatic clear_logs();
    tx_q.delete();
    we_addr_q.delete();
    we_data_q.delete();
    n_start = 0;
    n_en    = 0;
  endtask

  task automatic wait_start(input int budget, input string tag, input bit rand_bp,
                            input int target);
    int k = 0;
    while (n_start < target && k < budget) begin
      if (rand_bp) u_if.i_uart_tx_full = ($urandom_range(0, 2) == 0);
      step(1);
      k++;
    end
    u_if.i_uart_tx_full = 1'b0;
    check({tag, "_done"}, 64'(n_start >= target), 64'd1);
  endtask

  task automatic check_reply(input string tag, input logic [7:0] exp);
    check({tag, "_txlen"}, tx_q.size(), 1);
    check({tag, "_txbyte"}, tx_q[0], exp);
    check({tag, "_starts"}, n_start, 1);
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({u_if.o_uart_rd, u_if.o_uart_wr, u_if.o_uart_wdata, u_if.o_uart_tx_start,
                imem_we, imem_addr, imem_wdata, cpu_en, dbg_addr});
  endfunction

  // Loads ld_words; addresses restart at 0 and wrap at 2^ImemAw.
  task automatic run_load(input string tag, input bit rand_bp);
    int n = ld_words.size();
    clear_logs();
    push(8'h4C);
    push(8'(n % 256));
    foreach (ld_words[i]) for (int k = 0; k < 4; k++) push(8'((ld_words[i] >> (8 * k)) % 256));
    wait_start(n * 12 + 100, tag, rand_bp, 1);
    step(4);
    check({tag, "_nwr"}, we_addr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), we_addr_q[i], i % (1 << ImemAw));
      check($sformatf("%s_data%0d", tag, i), we_data_q[i], ld_words[i]);
    end
    check_reply(tag, 8'h06);
  endtask

  task automatic run_dump(input string tag, input bit rand_bp);
    logic [31:0] got;
    clear_logs();
    push(8'h44);
    wait_start(2000, tag, rand_bp, 1);
    step(4);
    check({tag, "_txlen"}, tx_q.size(), NRegs * 4);
    for (int r = 0; r < NRegs; r++) begin
      got = 0;
      for (int k = 0; k < 4; k++) got = got + (32'(tx_q[4 * r + k]) << (8 * k));
      check($sformatf("%s_reg%0d", tag, r), got, reg_file[r]);
    end
    check({tag, "_starts"}, n_start, 1);
  endtask

  initial begin
    logic [7:0] b;
    u_if.i_uart_tx_full = 1'b0;
    cpu_halt = 1'b0;
    for (int r = 0; r < NRegs; r++) reg_file[r] = 32'(r);

    // Reset state.
    step(3);
    check("reset_outputs", all_outputs(), 64'd0);
    rst_n = 1'b1;
    step(2);
    check("idle_outputs", all_outputs(), 64'd0);

    // Directed load of two words.
    ld_words = '{32'h00100513, 32'h00B505B3};
    run_load("load2", 1'b0);

    // Run until halt, with a command queued behind it.
    clear_logs();
    push(8'h52);
    push(8'h53);
    begin
      int k = 0;
      while (!cpu_en && k < 20) begin
        step(1);
        k++;
      end
    end
    check("run_en_rise", cpu_en, 1);
    step(19);
    check("run_rx_held", 64'(rx_wr - rx_rd), 64'd1);
    cpu_halt = 1'b1;
    step(1);
    cpu_halt = 1'b0;
    check("run_en_cycles", n_en, 20);
    wait_start(100, "run", 1'b0, 2);
    step(4);
    check("run_txlen", tx_q.size(), 2);
    check("run_halt_byte", tx_q[0], 8'h48);
    check("run_step_ack", tx_q[1], 8'h06);
    check("run_step_en_total", n_en, 21);
    check("run_starts", n_start, 2);

    // Halt already asserted on entry: enable for one cycle only.
    clear_logs();
    cpu_halt = 1'b1;
    push(8'h52);
    wait_start(50, "run_halt_entry", 1'b0, 1);
    cpu_halt = 1'b0;
    step(4);
    check("run_halt_entry_en", n_en, 1);
    check_reply("run_halt_entry", 8'h48);

    // Register dump with register index as data.
    run_dump("dump_idx", 1'b0);

    // NAK under TX backpressure.
    clear_logs();
    u_if.i_uart_tx_full = 1'b1;
    push(8'h7A);
    step(10);
    check("nak_no_wr_while_full", tx_q.size(), 0);
    check("nak_wdata_held", u_if.o_uart_wdata, 8'h15);
    check("nak_no_start_while_full", n_start, 0);
    u_if.i_uart_tx_full = 1'b0;
    wait_start(20, "nak", 1'b0, 1);
    step(4);
    check_reply("nak", 8'h15);

    // Randomized loads, dump and unknown commands with random backpressure.
    for (int t = 0; t < 3; t++) begin
      ld_words.delete();
      repeat ($urandom_range(1, 6)) ld_words.push_back($urandom);
      run_load($sformatf("rload%0d", t), 1'b1);
    end
    for (int r = 0; r < NRegs; r++) reg_file[r] = $urandom;
    run_dump("dump_rand", 1'b1);
    for (int t = 0; t < 4; t++) begin
      do b = 8'($urandom_range(0, 255));
      while (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h44);
      clear_logs();
      push(b);
      wait_start(50, $sformatf("rnak%0d", t), 1'b1, 1);
      step(4);
      check_reply($sformatf("rnak%0d", t), 8'h15);
    end

    // Reset in the middle of a load, then a step must work from a clean state.
    clear_logs();
    push(8'h4C);
    push(8'h02);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    step(8);
    check("midload_consumed", 64'(rx_wr - rx_rd), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midload_reset_outputs", all_outputs(), 64'd0);
    step(2);
    check("midload_reset_held", all_outputs(), 64'd0);
    rst_n = 1'b1;
    step(1);
    clear_logs();
    push(8'h53);
    wait_start(50, "post_reset_step", 1'b0, 1);
    step(4);
    check("post_reset_step_en", n_en, 1);
    check("post_reset_no_imem_wr", we_addr_q.size(), 0);
    check_reply("post_reset_step", 8'h06);

    // Count byte 0 loads 256 words; the address wraps at the last word.
    ld_words.delete();
    repeat (256) ld_words.push_back($urandom);
    run_load("wrap", 1'b0);
    check("wrap_last_addr", we_addr_q[255], 255);

    check("protocol_violations", n_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
